// File: rtl/pulpemu_trace_pkg.sv
// Shared types and sizing helpers for the PULP emulation instruction-trace buffer.
package pulpemu_trace_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RD_WORD_W = 8;

  typedef enum logic {
    TRACE_STOP = 1'b0,
    TRACE_WRAP = 1'b1
  } trace_mode_e;

  // One valid-mask word plus four words (cycles lo/hi, instr, pc) per core.
  function automatic int unsigned words_per_entry(input int unsigned nb_cores);
    return 1 + 4 * nb_cores;
  endfunction

  // Entry width: the packed record bits rounded up to whole 32-bit words.
  function automatic int unsigned entry_width(input int unsigned nb_cores);
    return words_per_entry(nb_cores) * WORD_W;
  endfunction

endpackage

// File: rtl/pulpemu_trace_ram.sv
// Single-clock simple dual-port RAM, write-first on an address collision.
module pulpemu_trace_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/pulpemu_trace_buffer.sv
// Instruction-trace capture ring buffer with stop-on-full / wrap modes and a
// word-granular, oldest-first host readout port.
module pulpemu_trace_buffer
  import pulpemu_trace_pkg::*;
#(
  parameter int unsigned NB_CORES  = 4,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned CYCLE_W   = 60,
  parameter int unsigned THRESHOLD = DEPTH - 16
) (
  input  logic                               ref_clk_i,
  input  logic                               rst_i,
  input  logic                               fetch_en_i,
  input  logic                               mode_wrap_i,
  input  logic [NB_CORES-1:0]                core_mask_i,
  input  logic [NB_CORES-1:0][63:0]          instr_trace_cycles_i,
  input  logic [NB_CORES-1:0][31:0]          instr_trace_instr_i,
  input  logic [NB_CORES-1:0][31:0]          instr_trace_pc_i,
  input  logic [NB_CORES-1:0]                instr_trace_valid_i,
  input  logic                               trace_flushed_i,
  output logic                               trace_wait_o,
  input  logic                               rd_req_i,
  input  logic [$clog2(DEPTH)-1:0]           rd_entry_i,
  input  logic [RD_WORD_W-1:0]               rd_word_i,
  output logic [WORD_W-1:0]                  rd_data_o,
  output logic                               rd_valid_o,
  output logic [$clog2(DEPTH):0]             count_o,
  output logic                               overflow_o,
  output logic [15:0]                        dropped_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WPE = words_per_entry(NB_CORES);
  localparam int unsigned EW  = entry_width(NB_CORES);
  localparam logic [31:0] CYC_HI_MASK = 32'((64'(1) << (CYCLE_W - 32)) - 64'(1));

  logic [NB_CORES-1:0]       valid_r;
  logic [NB_CORES-1:0][63:0] cycles_r;
  logic [NB_CORES-1:0][31:0] instr_r;
  logic [NB_CORES-1:0][31:0] pc_r;

  logic [NB_CORES-1:0]   mv;
  logic                  capture, full, write_en, lost;
  logic [AW-1:0]         write_addr, wr_ptr, old_ptr;
  logic [WPE-1:0][31:0]  entry_w, ram_words;
  logic [EW-1:0]         ram_q;
  trace_mode_e           mode;

  logic                  rd_req_q, rd_ok_q, rd_req_q2, rd_ok_q2;
  logic [AW-1:0]         rd_addr_q;
  logic [RD_WORD_W-1:0]  rd_word_q, rd_word_q2;
  logic [WORD_W-1:0]     word_sel;

  // Stage 0: record inputs are registered every cycle.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) valid_r <= '0;
    else       valid_r <= instr_trace_valid_i;
  end

  always_ff @(posedge ref_clk_i) begin
    cycles_r <= instr_trace_cycles_i;
    instr_r  <= instr_trace_instr_i;
    pc_r     <= instr_trace_pc_i;
  end

  assign mv         = valid_r & core_mask_i;
  assign capture    = fetch_en_i && (|mv);
  assign full       = (count_o == CW'(DEPTH));
  assign write_en   = capture && (trace_flushed_i || !full || (mode == TRACE_WRAP));
  assign lost       = capture && !trace_flushed_i && full;
  assign write_addr = trace_flushed_i ? '0 : wr_ptr;

  // Entry packing; cores outside the masked-valid set store zeros.
  always_comb begin
    entry_w    = '0;
    entry_w[0] = 32'(mv);
    for (int unsigned c = 0; c < NB_CORES; c++) begin
      if (mv[c]) begin
        entry_w[1 + 4*c] = cycles_r[c][31:0];
        entry_w[2 + 4*c] = cycles_r[c][63:32] & CYC_HI_MASK;
        entry_w[3 + 4*c] = instr_r[c];
        entry_w[4 + 4*c] = pc_r[c];
      end
    end
  end

  // Pointers, fill level and flags; a flush wins over a same-cycle capture.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      old_ptr      <= '0;
      count_o      <= '0;
      overflow_o   <= 1'b0;
      dropped_o    <= '0;
      trace_wait_o <= 1'b0;
      mode         <= TRACE_STOP;
    end else begin
      if (trace_flushed_i || (count_o == '0)) mode <= trace_mode_e'(mode_wrap_i);
      if (trace_flushed_i) begin
        wr_ptr       <= AW'(capture);
        old_ptr      <= '0;
        count_o      <= CW'(capture);
        overflow_o   <= 1'b0;
        dropped_o    <= '0;
        trace_wait_o <= 1'b0;
      end else begin
        if (write_en)          wr_ptr  <= wr_ptr + AW'(1);
        if (write_en && !full) count_o <= count_o + CW'(1);
        if (write_en && full)  old_ptr <= old_ptr + AW'(1);
        if (lost) begin
          overflow_o <= 1'b1;
          if (dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
        end
        if ((mode == TRACE_STOP) && (count_o >= CW'(THRESHOLD))) trace_wait_o <= 1'b1;
      end
    end
  end

  pulpemu_trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (ref_clk_i),
    .we    (write_en),
    .waddr (write_addr),
    .wdata (entry_w),
    .re    (rd_req_q),
    .raddr (rd_addr_q),
    .rdata (ram_q)
  );

  // Read pipeline: address/range check, RAM access, word mux.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      rd_req_q   <= 1'b0;
      rd_req_q2  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_req_q   <= rd_req_i;
      rd_req_q2  <= rd_req_q;
      rd_valid_o <= rd_req_q2;
      if (rd_req_q2) rd_data_o <= rd_ok_q2 ? word_sel : '0;
    end
  end

  always_ff @(posedge ref_clk_i) begin
    rd_addr_q  <= old_ptr + rd_entry_i;
    rd_ok_q    <= (CW'(rd_entry_i) < count_o) && (rd_word_i < RD_WORD_W'(WPE));
    rd_word_q  <= rd_word_i;
    rd_ok_q2   <= rd_ok_q;
    rd_word_q2 <= rd_word_q;
  end

  assign ram_words = ram_q;

  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < WPE; i++) begin
      if (rd_word_q2 == RD_WORD_W'(i)) word_sel = ram_words[i];
    end
  end

endmodule

// File: tb/tb_pulpemu_trace_buffer.sv
// Directed self-checking bench for pulpemu_trace_buffer (4 cores, 16 entries).
module tb_pulpemu_trace_buffer;

  localparam int unsigned NB  = 4;
  localparam int unsigned D   = 16;
  localparam int unsigned TH  = 12;
  localparam int unsigned CYW = 60;
  localparam int unsigned WPE = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_en, mode_wrap, flushed;
  logic [NB-1:0]     core_mask, valid;
  logic [NB-1:0][63:0] cycles;
  logic [NB-1:0][31:0] instr, pc;
  logic              wait_f;
  logic              rd_req;
  logic [3:0]        rd_entry;
  logic [7:0]        rd_word;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [4:0]        count;
  logic              overflow;
  logic [15:0]       dropped;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulpemu_trace_buffer #(
    .NB_CORES (NB), .DEPTH (D), .CYCLE_W (CYW), .THRESHOLD (TH)
  ) dut (
    .ref_clk_i            (clk),
    .rst_i                (rst),
    .fetch_en_i           (fetch_en),
    .mode_wrap_i          (mode_wrap),
    .core_mask_i          (core_mask),
    .instr_trace_cycles_i (cycles),
    .instr_trace_instr_i  (instr),
    .instr_trace_pc_i     (pc),
    .instr_trace_valid_i  (valid),
    .trace_flushed_i      (flushed),
    .trace_wait_o         (wait_f),
    .rd_req_i             (rd_req),
    .rd_entry_i           (rd_entry),
    .rd_word_i            (rd_word),
    .rd_data_o            (rd_data),
    .rd_valid_o           (rd_valid),
    .count_o              (count),
    .overflow_o           (overflow),
    .dropped_o            (dropped)
  );

  // Core c sees cycles base+256*c, instr A000_0000+low, pc 1000_0000+low.
  task automatic drive_rec(input logic [NB-1:0] v, input logic [63:0] base);
    valid = v;
    for (int c = 0; c < NB; c++) begin
      cycles[c] = base + 64'(c) * 64'd256;
      instr[c]  = 32'hA000_0000 + 32'(c) * 32'd256 + base[31:0];
      pc[c]     = 32'h1000_0000 + 32'(c) * 32'd256 + base[31:0];
    end
  endtask

  task automatic capture_n(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_rec(4'b0001, 64'(start + i));
    end
    @(negedge clk); valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic flush_buf();
    @(negedge clk); flushed = 1'b1;
    @(negedge clk); flushed = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] e, input logic [7:0] w,
                         output logic [31:0] d, output logic v);
    @(negedge clk); rd_req = 1'b1; rd_entry = e; rd_word = w;
    @(negedge clk); rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk); d = rd_data; v = rd_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (count !== 5'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (wait_f !== 1'b0)    begin failures++; $display("FAIL reset_wait got=%b exp=0", wait_f); end
    if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (dropped !== 16'd0)  begin failures++; $display("FAIL reset_dropped got=%0d exp=0", dropped); end
    if (rd_valid !== 1'b0)  begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (rd_data !== 32'd0)  begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d; logic v;
    capture_n(3, 10);
    checks++;
    if (count !== 5'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
    do_read(4'd0, 8'd0, d, v); checks++;
    if (d !== 32'd1 || v !== 1'b1) begin failures++; $display("FAIL basic_e0w0 got=%h/%b exp=1/1", d, v); end
    do_read(4'd0, 8'd1, d, v); checks++;
    if (d !== 32'd10) begin failures++; $display("FAIL basic_e0w1 got=%h exp=a", d); end
    do_read(4'd0, 8'd2, d, v); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL basic_e0w2 got=%h exp=0", d); end
    do_read(4'd1, 8'd3, d, v); checks++;
    if (d !== 32'hA000_000B) begin failures++; $display("FAIL basic_e1w3 got=%h exp=a000000b", d); end
    do_read(4'd2, 8'd1, d, v); checks++;
    if (d !== 32'd12) begin failures++; $display("FAIL basic_e2w1 got=%h exp=c", d); end
    do_read(4'd0, 8'd5, d, v); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL basic_e0w5 got=%h exp=0", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d; logic v;
    flush_buf();
    core_mask = 4'b0010;
    @(negedge clk); drive_rec(4'b0011, 64'hFFFF_0000_0000_0005);
    @(negedge clk); drive_rec(4'b0001, 64'd6);
    @(negedge clk); valid = '0;
    @(negedge clk);
    checks++;
    if (count !== 5'd1) begin failures++; $display("FAIL mask_count got=%0d exp=1", count); end
    do_read(4'd0, 8'd0, d, v); checks++;
    if (d !== 32'd2) begin failures++; $display("FAIL mask_e0w0 got=%h exp=2", d); end
    do_read(4'd0, 8'd1, d, v); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL mask_core0_cyc got=%h exp=0", d); end
    do_read(4'd0, 8'd4, d, v); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL mask_core0_pc got=%h exp=0", d); end
    do_read(4'd0, 8'd5, d, v); checks++;
    if (d !== 32'h0000_0105) begin failures++; $display("FAIL mask_core1_cyclo got=%h exp=105", d); end
    do_read(4'd0, 8'd6, d, v); checks++;
    if (d !== 32'h0FFF_0000) begin failures++; $display("FAIL mask_core1_cychi got=%h exp=0fff0000", d); end
    do_read(4'd0, 8'd7, d, v); checks++;
    if (d !== 32'hA000_0105) begin failures++; $display("FAIL mask_core1_instr got=%h exp=a0000105", d); end
    core_mask = 4'hF;
    fetch_en  = 1'b0;
    capture_n(2, 50);
    checks++;
    if (count !== 5'd1) begin failures++; $display("FAIL fetch_hold_count got=%0d exp=1", count); end
    fetch_en = 1'b1;
  endtask

  task automatic test_stop_full();
    logic [31:0] d; logic v;
    flush_buf();
    capture_n(11, 0);
    checks += 2;
    if (count !== 5'd11) begin failures++; $display("FAIL stop_count11 got=%0d exp=11", count); end
    if (wait_f !== 1'b0) begin failures++; $display("FAIL stop_wait11 got=%b exp=0", wait_f); end
    capture_n(1, 11);
    checks++;
    if (wait_f !== 1'b1) begin failures++; $display("FAIL stop_wait12 got=%b exp=1", wait_f); end
    capture_n(8, 12);
    checks += 4;
    if (count !== 5'd16)    begin failures++; $display("FAIL stop_count got=%0d exp=16", count); end
    if (dropped !== 16'd4)  begin failures++; $display("FAIL stop_dropped got=%0d exp=4", dropped); end
    if (overflow !== 1'b1)  begin failures++; $display("FAIL stop_overflow got=%b exp=1", overflow); end
    if (wait_f !== 1'b1)    begin failures++; $display("FAIL stop_wait got=%b exp=1", wait_f); end
    do_read(4'd0, 8'd1, d, v); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL stop_e0w1 got=%h exp=0", d); end
    do_read(4'd15, 8'd1, d, v); checks++;
    if (d !== 32'd15) begin failures++; $display("FAIL stop_e15w1 got=%h exp=f", d); end
    flush_buf();
    checks += 4;
    if (count !== 5'd0)    begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (dropped !== 16'd0) begin failures++; $display("FAIL flush_dropped got=%0d exp=0", dropped); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
    if (wait_f !== 1'b0)   begin failures++; $display("FAIL flush_wait got=%b exp=0", wait_f); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic v;
    @(negedge clk); mode_wrap = 1'b1;
    @(negedge clk);
    capture_n(20, 0);
    mode_wrap = 1'b0;
    checks += 4;
    if (count !== 5'd16)   begin failures++; $display("FAIL wrap_count got=%0d exp=16", count); end
    if (wait_f !== 1'b0)   begin failures++; $display("FAIL wrap_wait got=%b exp=0", wait_f); end
    if (dropped !== 16'd4) begin failures++; $display("FAIL wrap_dropped got=%0d exp=4", dropped); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL wrap_overflow got=%b exp=1", overflow); end
    do_read(4'd0, 8'd1, d, v); checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL wrap_e0w1 got=%h exp=4", d); end
    do_read(4'd15, 8'd1, d, v); checks++;
    if (d !== 32'd19) begin failures++; $display("FAIL wrap_e15w1 got=%h exp=13", d); end
    flush_buf();
  endtask

  task automatic test_flush_capture();
    logic [31:0] d; logic v;
    capture_n(18, 100);
    @(negedge clk); drive_rec(4'b0001, 64'd77);
    @(negedge clk); valid = '0; flushed = 1'b1;
    @(negedge clk); flushed = 1'b0;
    @(negedge clk);
    checks += 4;
    if (count !== 5'd1)    begin failures++; $display("FAIL fc_count got=%0d exp=1", count); end
    if (dropped !== 16'd0) begin failures++; $display("FAIL fc_dropped got=%0d exp=0", dropped); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL fc_overflow got=%b exp=0", overflow); end
    if (wait_f !== 1'b0)   begin failures++; $display("FAIL fc_wait got=%b exp=0", wait_f); end
    do_read(4'd0, 8'd1, d, v); checks++;
    if (d !== 32'd77) begin failures++; $display("FAIL fc_e0w1 got=%h exp=4d", d); end
  endtask

  task automatic test_oob_read();
    logic [31:0] d; logic v;
    flush_buf();
    capture_n(3, 30);
    do_read(4'd5, 8'd0, d, v); checks++;
    if (d !== 32'd0 || v !== 1'b1) begin failures++; $display("FAIL oob_entry got=%h/%b exp=0/1", d, v); end
    do_read(4'd0, 8'(WPE), d, v); checks++;
    if (d !== 32'd0 || v !== 1'b1) begin failures++; $display("FAIL oob_word got=%h/%b exp=0/1", d, v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [WPE];
    for (int i = 0; i < WPE; i++) exp_w[i] = 32'd0;
    exp_w[0] = 32'd1;
    exp_w[1] = 32'd31;
    exp_w[3] = 32'hA000_001F;
    exp_w[4] = 32'h1000_001F;
    for (int t = 0; t < WPE + 3; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_w[t-3]) begin
          failures++;
          $display("FAIL b2b_word%0d got=%h/%b exp=%h/1", t - 3, rd_data, rd_valid, exp_w[t-3]);
        end
      end
      if (t < WPE) begin rd_req = 1'b1; rd_entry = 4'd1; rd_word = 8'(t); end
      else rd_req = 1'b0;
    end
    @(negedge clk); checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", rd_valid); end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; mode_wrap = 1'b0; flushed = 1'b0;
    core_mask = 4'hF; valid = '0; cycles = '0; instr = '0; pc = '0;
    rd_req = 1'b0; rd_entry = '0; rd_word = '0;
    test_reset();
    test_basic();
    test_mask();
    test_stop_full();
    test_wrap();
    test_flush_capture();
    test_oob_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
